timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shares one interval counter among `NUM_REQ` requesters with round-robin arbitration. Each requester asks for an interval of `count + 1` cycles and receives a one-cycle `done` pulse when its interval expires. It sits in front of the shared timing resource, so blocks needing occasional delays do not each instantiate their own counter. An `abort` input cancels the interval in progress.

## Interface
- `NUM_REQ`, default 4: number of requesters; valid range 2–16.
- `COUNT_WIDTH`, default 16: width of each requested interval and of the internal counter.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  `NUM_REQ`  level request per requester.
- `count`  in  `NUM_REQ*COUNT_WIDTH`  requested limit per requester.
  - Requester i occupies bits `[i*COUNT_WIDTH +: COUNT_WIDTH]`.
- `abort`  in  1  cancel the current interval; ignored when idle.
- `grant`  out  `NUM_REQ`  one-hot, registered; high for the current owner while running, otherwise zero.
- `done`  out  `NUM_REQ`  one-hot, registered, one-cycle pulse to the owner on expiry.
- `busy`  out  1  registered; high while in RUNNING.

## Operation
- **State machine:** IDLE and RUNNING.
- **Registers:** `state`, `owner`, `limit` (`COUNT_WIDTH`), `timer` (`COUNT_WIDTH`), round-robin pointer `ptr`.
- **IDLE:**
  - If `req` is nonzero, select the first set bit searching `ptr`, `ptr+1`, … modulo `NUM_REQ`.
  - Next edge: state←RUNNING, `owner`←winner, `limit`←`count` slice of the winner, `timer`←0, `grant`←onehot(winner), `ptr`←(winner+1) mod `NUM_REQ`.
  - If `req` is zero, nothing changes.
- **RUNNING, `abort`=0, `timer`≠`limit`:**
  - `timer`←`timer`+1.
  - `req` is ignored in this state.
- **RUNNING, `abort`=0, `timer`==`limit`:**
  - Next edge: state←IDLE, `grant`←0, `done`←onehot(`owner`) for one cycle, `timer`←0.
- **RUNNING, `abort`=1:**
  - Next edge: state←IDLE, `grant`←0, `timer`←0, no `done` pulse.
  - `abort` wins over a simultaneous `timer`==`limit`.
- **Limit sampling:** `count` is sampled only at grant; later changes to it do not affect the running interval.
- **Width:** `timer` never exceeds `limit`, so it never wraps.
  - `limit` = all-ones is legal and gives 2^`COUNT_WIDTH` running cycles.
- **Requester protocol:**
  - Keep `req` high until `grant` is seen.
  - `req` still high in the `done` cycle is treated as a new request; this is the intended way to get periodic intervals.
  - Dropping `req` before grant withdraws the request without side effects.
- **Reset:** any time `rst_n` is low, `state`=IDLE, `owner`=0, `limit`=0, `timer`=0, `ptr`=0, and `grant`, `done`, `busy` are all 0.
  - A reset asserted mid-interval discards it with no `done` pulse.

## Timing
- Request seen in IDLE at cycle T → `grant` and `busy` high from cycle T+1.
- The interval runs L+1 cycles with `grant` high (L = sampled `limit`).
- `done` is high in cycle T+L+2, the same cycle `grant` and `busy` fall.
- `done` cycle is IDLE: a pending `req` there is granted at T+L+3. Back-to-back throughput is therefore one interval per L+2 cycles.
- `abort` high in RUNNING cycle A → `grant`/`busy` low from A+1; arbitration is possible in A+1.
- `done` and `grant` are never high in the same cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-interval with `limit`=10 → `grant`, `done`, `busy` go 0 immediately. After release, no `done` pulse; requester 0 has priority.
- **Single request:** `req`=0001, `count[0]`=3 at cycle 0 → `grant`=0001 in cycles 1–4, `done`=0001 in cycle 5 only.
- **Zero limit:** `count`=0 → `grant` high for exactly 1 cycle, `done` the following cycle.
- **Round robin:** all four `req` held high, all `count`=1 → grant order 0,1,2,3,0. Each grant lasts 2 cycles, with 1 done/idle cycle between grants.
- **Abort priority:** `count`=5, `abort` pulsed in the cycle `timer`==5 → no `done`, `busy` low next cycle. Then `abort` pulsed while IDLE → no effect.
- **Limit sampling:** change `count[2]` from 4 to 9 one cycle after grant → `done` still arrives at cycle grant+5. Separately, all-ones `limit` with `COUNT_WIDTH`=4 → 16 `grant` cycles, no wrap.

Source files
------------

// File: rtl/timer_arbiter_if.sv
// -----------------------------------------------------------------------------
// timer_arbiter_if
//   Request/response bundle between the requesters and the shared interval
//   timer.
//
//   req    : level request, one bit per requester
//   count  : requested limit per requester, requester i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   abort  : cancel the interval in progress
//   grant  : one-hot owner of the running interval
//   done   : one-hot, one-cycle expiry pulse to the owner
//   busy   : an interval is running
//
//   master : requester side (drives req/count/abort)
//   slave  : arbiter side   (drives grant/done/busy)
// -----------------------------------------------------------------------------
interface timer_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 16
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*COUNT_WIDTH-1:0] count;
    logic                           abort;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             done;
    logic                           busy;

    modport master (
        output req, count, abort,
        input  grant, done, busy
    );

    modport slave (
        input  req, count, abort,
        output grant, done, busy
    );
endinterface

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//   One interval counter shared by NUM_REQ requesters under round-robin
//   arbitration. A winner gets an interval of count+1 cycles (grant high),
//   followed by a one-cycle done pulse in the cycle grant falls. abort ends
//   the running interval without a done pulse.
//
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : timer_arbiter_if.slave (req/count/abort in, grant/done/busy out)
// -----------------------------------------------------------------------------
module timer_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    timer_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, RUNNING} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q,   ptr_d;
    logic [COUNT_WIDTH-1:0] limit_q, limit_d;
    logic [COUNT_WIDTH-1:0] timer_q, timer_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q,  done_d;
    logic                   busy_q,  busy_d;

    // Per-requester view of the flat count bus.
    logic [NUM_REQ-1:0][COUNT_WIDTH-1:0] cnt_arr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign cnt_arr[i] = bus.count[i*COUNT_WIDTH +: COUNT_WIDTH];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Round-robin pick: first set req bit starting at ptr, wrapping.
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state / output logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        limit_d = limit_q;
        timer_d = timer_q;
        grant_d = grant_q;
        done_d  = '0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUNNING;
                    owner_d = win;
                    // count is only sampled here; later changes are ignored.
                    limit_d = cnt_arr[win];
                    timer_d = '0;
                    grant_d = onehot(win);
                    busy_d  = 1'b1;
                    ptr_d   = (win == LAST_IDX) ? '0 : win + 1'b1;
                end
            end
            RUNNING: begin
                // abort beats a simultaneous expiry: no done pulse.
                if (bus.abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                    timer_d = '0;
                    busy_d  = 1'b0;
                end else if (timer_q == limit_q) begin
                    state_d = IDLE;
                    grant_d = '0;
                    done_d  = onehot(owner_q);
                    timer_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    // Stops at limit, so an all-ones limit never wraps.
                    timer_d = timer_q + COUNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            limit_q <= '0;
            timer_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            limit_q <= limit_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

    // Structural invariants of the outputs.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_done_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));
    a_no_overlap:   assert property (@(posedge clk) disable iff (!rst_n) (grant_q & done_q) == '0);
    a_busy_match:   assert property (@(posedge clk) disable iff (!rst_n) busy_q == (grant_q != '0));
endmodule

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
//   Scenario tasks push the expected grant/done/busy of each upcoming cycle
//   into a scoreboard queue as they drive stimulus, then pop and compare one
//   entry per cycle. dut uses COUNT_WIDTH=16; dut2 uses COUNT_WIDTH=4 for the
//   all-ones limit case.
// -----------------------------------------------------------------------------
module tb_timer_arbiter;
    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int CW2 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_arbiter_if #(.NUM_REQ(N), .COUNT_WIDTH(CW))  bus  ();
    timer_arbiter_if #(.NUM_REQ(N), .COUNT_WIDTH(CW2)) bus2 ();

    timer_arbiter #(.NUM_REQ(N), .COUNT_WIDTH(CW))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    timer_arbiter #(.NUM_REQ(N), .COUNT_WIDTH(CW2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct packed {
        logic [N-1:0] g;
        logic [N-1:0] d;
        logic         b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic push(input logic [N-1:0] g, input logic [N-1:0] d, input logic b);
        exp_t x;
        x.g = g; x.d = d; x.b = b;
        sb.push_back(x);
    endtask

    // Advance one cycle; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.count  = '0;
        bus.abort  = 1'b0;
        bus2.req   = '0;
        bus2.count = '0;
        bus2.abort = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.grant, bus.done, bus.busy} !== '0) begin
            failures++;
            $display("FAIL reset_idle got grant=%b done=%b busy=%b exp all 0", bus.grant, bus.done, bus.busy);
        end
        bus.count[0 +: CW] = 16'd10;
        bus.req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            push(4'b0001, 4'b0000, 1'b1);
            step();
            if (cyc == 1) bus.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL reset_pre cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
        // Assert reset mid-interval, between clock edges.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.grant, bus.done, bus.busy} !== '0) begin
            failures++;
            $display("FAIL reset_async got grant=%b done=%b busy=%b exp all 0", bus.grant, bus.done, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        cyc = 0;
        // Original interval would have expired around here: no done allowed.
        for (int i = 0; i < 14; i++) begin
            push(4'b0000, 4'b0000, 1'b0);
            step();
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL reset_nodone cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
        // Pointer restarts at 0: requester 0 wins among all.
        bus.count = '0;
        bus.req   = 4'b1111;
        push(4'b0001, 4'b0000, 1'b1);
        push(4'b0000, 4'b0001, 1'b0);
        push(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) bus.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL reset_prio cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.count[0 +: CW] = 16'd3;
        bus.req = 4'b0001;
        for (int i = 0; i < 4; i++) push(4'b0001, 4'b0000, 1'b1);
        push(4'b0000, 4'b0001, 1'b0);
        push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            if (cyc == 1) bus.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL single cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
    endtask

    task automatic test_zero_limit();
        do_reset();
        bus.count[0 +: CW] = 16'd0;
        bus.req = 4'b0001;
        push(4'b0001, 4'b0000, 1'b1);
        push(4'b0000, 4'b0001, 1'b0);
        push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            if (cyc == 1) bus.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL zero_limit cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] oh;
        do_reset();
        for (int i = 0; i < N; i++) bus.count[i*CW +: CW] = 16'd1;
        bus.req = 4'b1111;
        // Expected order 0,1,2,3,0: 2 grant cycles then 1 done cycle each.
        for (int r = 0; r < 5; r++) begin
            oh = 4'b0001 << (r % N);
            push(oh, 4'b0000, 1'b1);
            push(oh, 4'b0000, 1'b1);
            push(4'b0000, oh, 1'b0);
        end
        push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            if (cyc == 13) bus.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL round_robin cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.count[0 +: CW] = 16'd2;
        bus.req = 4'b0001;
        // Held req re-granted right after done: one interval per L+2 cycles.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) push(4'b0001, 4'b0000, 1'b1);
            push(4'b0000, 4'b0001, 1'b0);
        end
        push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            if (cyc == 5) bus.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.count[0 +: CW] = 16'd3;
        bus.count[1*CW +: CW] = 16'd3;
        bus.req = 4'b0001;
        for (int i = 0; i < 4; i++) push(4'b0001, 4'b0000, 1'b1);
        push(4'b0000, 4'b0001, 1'b0);
        push(4'b0000, 4'b0000, 1'b0);
        push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            // Requester 1 asks during the interval, then withdraws before done.
            if (cyc == 1) bus.req = 4'b0010;
            if (cyc == 3) bus.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL withdraw cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        bus.count[0 +: CW] = 16'd5;
        bus.req = 4'b0001;
        // timer==5 in cycle 6; abort there suppresses done.
        for (int i = 0; i < 6; i++) push(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            if (cyc == 1) bus.req = '0;
            bus.abort = (cyc == 6) || (cyc == 8);
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL abort cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_limit_sampling();
        do_reset();
        bus.count[2*CW +: CW] = 16'd4;
        bus.req = 4'b0100;
        for (int i = 0; i < 5; i++) push(4'b0100, 4'b0000, 1'b1);
        push(4'b0000, 4'b0100, 1'b0);
        push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            if (cyc == 1) bus.req = '0;
            if (cyc == 2) bus.count[2*CW +: CW] = 16'd9;
            e = sb.pop_front();
            checks++;
            if ({bus.grant, bus.done, bus.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL limit_sample cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus.grant, bus.done, bus.busy, e.g, e.d, e.b);
            end
        end
    endtask

    task automatic test_all_ones();
        do_reset();
        bus2.count[0 +: CW2] = 4'hF;
        bus2.req = 4'b0001;
        for (int i = 0; i < 16; i++) push(4'b0001, 4'b0000, 1'b1);
        push(4'b0000, 4'b0001, 1'b0);
        push(4'b0000, 4'b0000, 1'b0);
        while (sb.size() != 0) begin
            step();
            if (cyc == 1) bus2.req = '0;
            e = sb.pop_front();
            checks++;
            if ({bus2.grant, bus2.done, bus2.busy} !== {e.g, e.d, e.b}) begin
                failures++;
                $display("FAIL all_ones cyc=%0d got g=%b d=%b b=%b exp g=%b d=%b b=%b", cyc, bus2.grant, bus2.done, bus2.busy, e.g, e.d, e.b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_limit();
        test_round_robin();
        test_back_to_back();
        test_withdraw();
        test_abort();
        test_limit_sampling();
        test_all_ones();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
